// File: rtl/seq_nibble_subtractor_pkg.sv
// Shared types and helpers for the nibble-serial subtractor controller.
// Holds the FSM state encoding, the slice width and the signed-overflow equation.
package sub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  // Signed overflow of a subtraction: operands of opposite sign and the result sign departs from the minuend.
  function automatic logic ovf_calc(input logic x_msb, input logic y_msb, input logic d_msb);
    return (x_msb ^ y_msb) & (d_msb ^ x_msb);
  endfunction

endpackage

// File: rtl/seq_nibble_subtractor_if.sv
// Request/result bundle for the subtractor.
// Handshake: start is a level sampled on a rising edge while the controller is IDLE or DONE; done is a one-cycle result strobe with no back-pressure.
interface seq_nibble_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  modport master (
    output start, X, Y, Bin,
    input  busy, done, Diff, Bout, Ovf
  );

  modport slave (
    input  start, X, Y, Bin,
    output busy, done, Diff, Bout, Ovf
  );
endinterface

// File: rtl/seq_nibble_subtractor_bls4_slice.sv
// Combinational 4-bit borrow-lookahead subtractor slice.
// Every internal borrow is formed directly from generate/propagate terms instead of rippling.
module bls4_slice (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Bin,
  output logic [3:0] Diff,
  output logic       Bout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] q;
  logic [4:0] b;

  assign p = X ^ Y;
  assign g = ~X & Y;
  // A borrow passes through a bit position when its operand bits are equal.
  assign q = ~p;

  assign b[0] = Bin;
  assign b[1] = g[0] | (q[0] & Bin);
  assign b[2] = g[1] | (q[1] & g[0]) | (q[1] & q[0] & Bin);
  assign b[3] = g[2] | (q[2] & g[1]) | (q[2] & q[1] & g[0]) | (q[2] & q[1] & q[0] & Bin);
  assign b[4] = g[3] | (q[3] & g[2]) | (q[3] & q[2] & g[1]) | (q[3] & q[2] & q[1] & g[0])
              | (q[3] & q[2] & q[1] & q[0] & Bin);

  assign Diff = p ^ b[3:0];
  assign Bout = b[4];
endmodule

// File: rtl/seq_nibble_subtractor.sv
// Nibble-serial WIDTH-bit subtractor: one shared 4-bit slice is stepped LSB-first over the operands,
// carrying the borrow between cycles, with a one-cycle done strobe at the end.
module seq_nibble_subtractor
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_nibble_subtractor_if.slave  bus,
  output state_e                  dbg_state
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int KW  = $clog2(NIB);

  state_e                state;
  logic [KW-1:0]         k;
  logic [WIDTH-1:0]      x_r;
  logic [WIDTH-1:0]      y_r;
  logic [WIDTH-1:0]      diff_r;
  logic                  borrow_r;
  logic                  bout_r;
  logic                  ovf_r;
  logic                  busy_r;
  logic                  done_r;

  logic [NIBBLE_W-1:0]   x_nib;
  logic [NIBBLE_W-1:0]   y_nib;
  logic [NIBBLE_W-1:0]   s_diff;
  logic                  s_bout;

  // Operands stay in place; the active nibble is picked by index.
  always_comb begin
    x_nib = '0;
    y_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (k == KW'(i)) begin
        x_nib = x_r[i*NIBBLE_W +: NIBBLE_W];
        y_nib = y_r[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  bls4_slice u_slice (
    .X    (x_nib),
    .Y    (y_nib),
    .Bin  (borrow_r),
    .Diff (s_diff),
    .Bout (s_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      x_r      <= '0;
      y_r      <= '0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state != RUN) begin
        if (bus.start) begin
          state    <= RUN;
          busy_r   <= 1'b1;
          k        <= '0;
          x_r      <= bus.X;
          y_r      <= bus.Y;
          borrow_r <= bus.Bin;
          diff_r   <= '0;
          bout_r   <= 1'b0;
          ovf_r    <= 1'b0;
        end else begin
          state <= IDLE;
        end
      end else begin
        for (int i = 0; i < NIB; i++) begin
          if (k == KW'(i)) diff_r[i*NIBBLE_W +: NIBBLE_W] <= s_diff;
        end
        borrow_r <= s_bout;
        if (k == KW'(NIB - 1)) begin
          state  <= DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          bout_r <= s_bout;
          // The last slice produces the result MSB, so overflow is resolved on the same edge.
          ovf_r  <= ovf_calc(x_r[WIDTH-1], y_r[WIDTH-1], s_diff[NIBBLE_W-1]);
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.Diff  = diff_r;
  assign bus.Bout  = bout_r;
  assign bus.Ovf   = ovf_r;
  assign dbg_state = state;
endmodule

// File: tb/tb_seq_nibble_subtractor.sv
// Bench for seq_nibble_subtractor: directed corner cases plus randomized start/operand traffic,
// with a cycle-level reference model feeding an expected-result queue drained by a monitor.
module tb_seq_nibble_subtractor;
  import sub_ctrl_pkg::*;

  localparam int W   = 16;
  localparam int NIB = W / 4;
  localparam int EW  = W + 2;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  seq_nibble_subtractor_if #(.WIDTH(W)) bus ();

  seq_nibble_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            vectors;
  int            miscompares;
  int            phase;
  logic          done_exp;

  function automatic logic [EW-1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
    int unsigned xi, yi, d;
    logic [W-1:0] dv;
    logic         bo, ov;
    xi = int'(x);
    yi = int'(y) + int'(b);
    d  = (xi + 32'h0001_0000 - yi) % 32'h0001_0000;
    dv = d[W-1:0];
    bo = (xi < yi);
    ov = (x[W-1] != y[W-1]) && (dv[W-1] != x[W-1]);
    return {ov, bo, dv};
  endfunction

  // Reference timing: an accept starts NIB busy cycles, followed by one done cycle in which a new accept is legal.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 0;
      done_exp <= 1'b0;
      exp_q.delete();
    end else begin
      done_exp <= 1'b0;
      if (phase == 0) begin
        if (bus.start) begin
          exp_q.push_back(ref_sub(bus.X, bus.Y, bus.Bin));
          phase <= NIB;
        end
      end else begin
        phase <= phase - 1;
        if (phase == 1) done_exp <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", EW'(bus.busy), EW'(phase != 0));
      check("done", EW'(bus.done), EW'(done_exp));
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", EW'(1), EW'(0));
        end else begin
          check("result{Ovf,Bout,Diff}", {bus.Ovf, bus.Bout, bus.Diff}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
    @(negedge clk);
    bus.start = s;
    bus.X     = x;
    bus.Y     = y;
    bus.Bin   = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
    drive(1'b1, x, y, b);
    idle(NIB + 2);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] dx [5] = '{16'h1234, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF};
  logic [W-1:0] dy [5] = '{16'h0235, 16'h0001, 16'h0005, 16'h0001, 16'hFFFF};
  logic         db [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.X       = '0;
    bus.Y       = '0;
    bus.Bin     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_diff", EW'(bus.Diff), EW'(0));
    check("reset_bout_ovf", EW'({bus.Bout, bus.Ovf}), EW'(0));
    check("reset_state", EW'(dbg_state), EW'(IDLE));

    for (int i = 0; i < 5; i++) op(dx[i], dy[i], db[i]);

    // A second start during RUN must be dropped.
    drive(1'b1, 16'h4321, 16'h1111, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    idle(NIB + 2);

    // Reset in the third RUN cycle aborts the operation.
    drive(1'b1, 16'hBEEF, 16'h1234, 1'b1);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_diff", EW'(bus.Diff), EW'(0));
    check("abort_state", EW'(dbg_state), EW'(IDLE));
    op(16'hCAFE, 16'h0BAD, 1'b0);

    // Start held high: back-to-back operations with fresh operands every cycle.
    for (int i = 0; i < 6 * (NIB + 1); i++) drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
    idle(NIB + 2);

    // Random traffic, start toggled freely.
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 2) == 0), W'($urandom), W'($urandom), 1'($urandom));
    idle(NIB + 3);

    check("queue_drained", EW'(exp_q.size()), EW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
